// File: rtl/period_finder_seq.sv
// Multiplicative-order finder: smallest r>=1 with base^r == 1 (mod modulus),
// using a shared bit-serial shift-add modular multiplier and valid/ready handshakes.
module period_finder_seq #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_PERIOD = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] base,
  input  logic             abort,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] period,
  output logic [1:0]       status,
  output logic [WIDTH-1:0] mu_counter
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_R    = WIDTH'(MAX_PERIOD);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  localparam logic [1:0] ST_OK          = 2'd0;
  localparam logic [1:0] ST_BAD_MOD     = 2'd1;
  localparam logic [1:0] ST_NOT_COPRIME = 2'd2;
  localparam logic [1:0] ST_NO_PERIOD   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_CHECK,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] mu_q, mu_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [1:0]       status_q, status_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   t_dbl;
  logic [WIDTH:0]   t_red;
  logic [WIDTH:0]   t_add;
  logic [WIDTH-1:0] step_res;

  // One MSB-first shift-add step: prod = 2*prod (+ mcand) mod m, operands kept below m
  always_comb begin
    m_ext    = {1'b0, m_q};
    t_dbl    = {prod_q, 1'b0};
    t_red    = (t_dbl >= m_ext) ? (t_dbl - m_ext) : t_dbl;
    t_add    = mplier_q[WIDTH-1] ? (t_red + {1'b0, mcand_q}) : t_red;
    step_res = WIDTH'((t_add >= m_ext) ? (t_add - m_ext) : t_add);
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    r_d      = r_q;
    mu_d     = mu_q;
    period_d = period_q;
    status_d = status_q;
    valid_d  = valid_q;

    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_valid && !abort) begin
            m_d      = modulus;
            mu_d     = '0;
            period_d = '0;
            status_d = ST_OK;
            mcand_d  = ONE;
            mplier_d = base;
            prod_d   = '0;
            cnt_d    = '0;
            if (modulus < WIDTH'(2)) begin
              // Result is presented one cycle later from DONE
              state_d  = S_DONE;
              status_d = ST_BAD_MOD;
            end else begin
              state_d = S_REDUCE;
            end
          end
        end

        S_REDUCE: begin
          prod_d   = step_res;
          mplier_d = mplier_q << 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            mcand_d = step_res;
            acc_d   = step_res;
            r_d     = ONE;
            state_d = S_CHECK;
          end
        end

        S_CHECK: begin
          if (acc_q == ONE) begin
            state_d  = S_DONE;
            status_d = ST_OK;
            period_d = r_q;
            valid_d  = 1'b1;
          end else if (acc_q == '0) begin
            state_d  = S_DONE;
            status_d = ST_NOT_COPRIME;
            valid_d  = 1'b1;
          end else if (r_q == MAX_R) begin
            state_d  = S_DONE;
            status_d = ST_NO_PERIOD;
            valid_d  = 1'b1;
          end else begin
            state_d  = S_MUL;
            prod_d   = '0;
            mplier_d = acc_q;
            cnt_d    = '0;
          end
        end

        S_MUL: begin
          prod_d   = step_res;
          mplier_d = mplier_q << 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            acc_d   = step_res;
            r_d     = r_q + ONE;
            mu_d    = (mu_q == ALL_ONES) ? mu_q : (mu_q + ONE);
            state_d = S_CHECK;
          end
        end

        S_DONE: begin
          if (valid_q && result_ready) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      r_q      <= '0;
      mu_q     <= '0;
      period_q <= '0;
      status_q <= ST_OK;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      r_q      <= r_d;
      mu_q     <= mu_d;
      period_q <= period_d;
      status_q <= status_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign start_ready  = ready_q;
  assign result_valid = valid_q;
  assign period       = period_q;
  assign status       = status_q;
  assign mu_counter   = mu_q;

endmodule

// File: tb/tb_period_finder_seq.sv
// Bench for period_finder_seq (WIDTH=4): directed jobs, an order-search model
// evaluated per accepted job, and a per-cycle compare against that model.
module tb_period_finder_seq;

  localparam int W    = 4;
  localparam int MAXP = (1 << W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  logic         clk;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] modulus;
  logic [W-1:0] base;
  logic         abort;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] period;
  logic [1:0]   status;
  logic [W-1:0] mu_counter;

  int n_tests = 0;
  int n_fail  = 0;

  period_finder_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .modulus      (modulus),
    .base         (base),
    .abort        (abort),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .period       (period),
    .status       (status),
    .mu_counter   (mu_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Order search straight from the definition: r counts candidates b^1, b^2, ...
  task automatic model_job(input int m, input int b, output int lat,
                           output int st, output int per, output int mu);
    int br;
    int acc;
    int r;
    if (m < 2) begin
      lat = 1; st = 1; per = 0; mu = 0;
    end else begin
      br  = b % m;
      acc = br;
      r   = 1;
      st  = 0;
      per = 0;
      forever begin
        if (acc == 1) begin st = 0; per = r; break; end
        if (acc == 0) begin st = 2; break; end
        if (r == MAXP) begin st = 3; break; end
        acc = (acc * br) % m;
        r++;
      end
      lat = r * (W + 1);
      mu  = r - 1;
    end
  endtask

  int mode = M_IDLE;
  int cnt, j_lat, j_st, j_per, j_mu;
  int e_valid, e_period, e_status, e_mu;
  bit mu_known   = 1'b1;
  bit model_live = 1'b0;

  // Reference model, advanced on every rising edge from the sampled inputs
  always @(posedge clk) begin
    if (reset) begin
      mode = M_IDLE; e_valid = 0; e_period = 0; e_status = 0; e_mu = 0;
      mu_known = 1'b1; model_live = 1'b1;
    end else begin
      case (mode)
        M_IDLE: if (start_valid && !abort) begin
          model_job(int'(modulus), int'(base), j_lat, j_st, j_per, j_mu);
          e_period = 0; e_status = 0; e_mu = 0; mu_known = 1'b1;
          cnt = 0; mode = M_BUSY;
        end
        M_BUSY: if (abort) begin
          mode = M_IDLE; mu_known = 1'b0;
        end else begin
          cnt++;
          if (cnt == j_lat) begin
            mode = M_DONE; e_valid = 1;
            e_period = j_per; e_status = j_st; e_mu = j_mu;
          end
        end
        M_DONE: if (abort || result_ready) begin
          mode = M_IDLE; e_valid = 0;
        end
        default: mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("start_ready", int'(start_ready), (mode == M_IDLE) ? 1 : 0);
      chk("result_valid", int'(result_valid), e_valid);
      if (mode != M_BUSY) begin
        chk("period", int'(period), e_period);
        chk("status", int'(status), e_status);
        if (mu_known) chk("mu_counter", int'(mu_counter), e_mu);
      end
    end
  end

  task automatic accept(input int m, input int b);
    start_valid = 1'b1;
    modulus     = W'(m);
    base        = W'(b);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int edges);
    edges = 0;
    while (!result_valid && edges < limit) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("valid_within_bound", int'(result_valid), 1);
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("valid_dropped", int'(result_valid), 0);
  endtask

  task automatic job_lit(input string tag, input int m, input int b, input int lat,
                         input int st, input int per, input int mu);
    int e;
    accept(m, b);
    wait_valid(200, e);
    chk({tag, "_latency"}, e, lat);
    chk({tag, "_status"}, int'(status), st);
    chk({tag, "_period"}, int'(period), per);
    chk({tag, "_mu"}, int'(mu_counter), mu);
    release_result();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    reset = 1'b1; start_valid = 1'b0; abort = 1'b0; result_ready = 1'b0;
    modulus = '0; base = '0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_mu", int'(mu_counter), 0);

    // 2 mod 15 has order 4; hold result unaccepted for 5 cycles
    accept(15, 2);
    wait_valid(200, e);
    chk("m15b2_latency", e, 20);
    chk("m15b2_period", int'(period), 4);
    chk("m15b2_mu", int'(mu_counter), 3);
    repeat (5) @(posedge clk); #1;
    chk("hold_valid", int'(result_valid), 1);
    chk("hold_period", int'(period), 4);
    chk("hold_status", int'(status), 0);
    release_result();

    // 10 mod 7 = 3, order 6; start_valid kept high with a bad modulus while busy
    start_valid = 1'b1; modulus = 4'd7; base = 4'd10;
    @(posedge clk); #1;
    modulus = 4'd1; base = 4'd0;
    wait_valid(200, e);
    start_valid = 1'b0;
    chk("m7b10_latency", e, 30);
    chk("m7b10_status", int'(status), 0);
    chk("m7b10_period", int'(period), 6);
    chk("m7b10_mu", int'(mu_counter), 5);
    release_result();

    job_lit("m6b2", 6, 2, 75, 3, 0, 14);
    job_lit("m9b0", 9, 0, 5, 2, 0, 0);
    job_lit("m1", 1, 5, 1, 1, 0, 0);
    job_lit("m0", 0, 3, 1, 1, 0, 0);
    job_lit("m13b5", 13, 5, 20, 0, 4, 3);

    // Abort sampled on the 7th edge after accept
    accept(15, 2);
    repeat (6) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_ready", int'(start_ready), 1);
    chk("abort_valid", int'(result_valid), 0);
    repeat (25) @(posedge clk); #1;
    chk("abort_no_result", int'(result_valid), 0);
    job_lit("m7b3", 7, 3, 30, 0, 6, 5);

    // Abort in DONE beats result_ready and start; abort in IDLE blocks start
    accept(9, 0);
    wait_valid(200, e);
    abort = 1'b1; result_ready = 1'b1; start_valid = 1'b1;
    modulus = 4'd7; base = 4'd3;
    @(posedge clk); #1;
    chk("done_abort_valid", int'(result_valid), 0);
    chk("done_abort_status_held", int'(status), 2);
    @(posedge clk); #1;
    chk("idle_abort_blocks", int'(start_ready), 1);
    abort = 1'b0; result_ready = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("accepted_after_abort", int'(start_ready), 0);
    wait_valid(200, e);
    chk("post_abort_latency", e, 30);
    chk("post_abort_period", int'(period), 6);
    release_result();

    // Synchronous reset in the third multiply round
    accept(15, 2);
    repeat (17) @(posedge clk); #1;
    chk("pre_reset_mu", int'(mu_counter), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_valid", int'(result_valid), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_status", int'(status), 0);
    chk("midrst_mu", int'(mu_counter), 0);
    chk("midrst_ready", int'(start_ready), 1);
    job_lit("after_reset", 15, 7, 20, 0, 4, 3);

    repeat (2) @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
